tlut_sequencer: RTL and testbench

TLUT_SEQUENCER -- requirements
Module: tlut_sequencer

---
 rtl/tlut_sequencer_if.sv | 38 +++
 rtl/tlut_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_tlut_sequencer.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlut_sequencer_if.sv
// ---------------------------------------------------------------------------
// tlut_sequencer_if
// Purpose : bundles the two handshakes of the T-LUT sequencer: the operand
//           input channel (valid/ready + activations + weights) and the
//           result output channel (valid/ready + captured result vector).
// Ports   : in_valid/in_act/in_wgt   producer -> sequencer
//           in_ready                 sequencer -> producer
//           out_valid/out_result     sequencer -> consumer
//           out_ready                consumer  -> sequencer
// Modports: master = the environment around the sequencer,
//           slave  = the sequencer itself.
// ---------------------------------------------------------------------------
interface tlut_sequencer_if #(
  parameter int INPUT_WIDTH  = 4,
  parameter int WEIGHT_WIDTH = 8,
  parameter int DIM_A        = 4,
  parameter int DIM_C        = 4,
  parameter int ACC_WIDTH    = 16,
  parameter int DIM_MULT     = 16
);
  logic                             in_valid;
  logic                             in_ready;
  logic [DIM_A*INPUT_WIDTH-1:0]     in_act;
  logic [DIM_C*WEIGHT_WIDTH-1:0]    in_wgt;
  logic                             out_valid;
  logic                             out_ready;
  logic [DIM_MULT*ACC_WIDTH-1:0]    out_result;

  modport master (
    output in_valid, in_act, in_wgt, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_act, in_wgt, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/tlut_sequencer.sv
// ---------------------------------------------------------------------------
// tlut_sequencer
// Purpose : drives one temporal-LUT SIMD cell through a full window.
//           An accepted operand set is latched onto the cell inputs, the
//           cell is given one LOAD cycle to settle, then enabled for exactly
//           N = 2^INPUT_WIDTH cycles, then left for TREE_LAT cycles while
//           its adder tree drains.  The cell's accumulated products are
//           captured on the final drain edge and offered on the output
//           handshake until consumed.
// Ports   : clk, rst_n          single rising-edge clock, async active-low reset
//           bus_if (slave)      operand input and result output handshakes
//           cell_enable         registered enable into the SIMD cell
//           cell_input_bin      latched activations into the cell
//           cell_weight_bin     latched weights into the cell
//           cell_mult           accumulated products returned by the cell
//           busy                high whenever the sequencer is not IDLE
//           perf_ops/perf_stall only with TLUT_SEQ_PERF_EN defined:
//                               saturating counts of completed output
//                               handshakes and of stalled HOLD cycles
// Config  : `define TLUT_SEQ_PERF_EN to add the performance counters.
// ---------------------------------------------------------------------------
module tlut_sequencer #(
  parameter int INPUT_WIDTH  = 4,
  parameter int WEIGHT_WIDTH = 8,
  parameter int DIM_A        = 4,
  parameter int DIM_C        = 4,
  parameter int ACC_WIDTH    = 16,
  parameter int DIM_MULT     = 16,
  parameter int TREE_LAT     = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  tlut_sequencer_if.slave                bus_if,
  output logic                           cell_enable,
  output logic [DIM_A*INPUT_WIDTH-1:0]   cell_input_bin,
  output logic [DIM_C*WEIGHT_WIDTH-1:0]  cell_weight_bin,
  input  logic [DIM_MULT*ACC_WIDTH-1:0]  cell_mult,
  output logic                           busy
`ifdef TLUT_SEQ_PERF_EN
  ,
  output logic [15:0]                    perf_ops,
  output logic [15:0]                    perf_stall
`endif
);

  localparam int N     = 1 << INPUT_WIDTH;
  localparam int CNT_W = INPUT_WIDTH + 1;
  localparam int ACT_W = DIM_A * INPUT_WIDTH;
  localparam int WGT_W = DIM_C * WEIGHT_WIDTH;
  localparam int RES_W = DIM_MULT * ACC_WIDTH;

  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(N - 1);
  // TREE_LAT is limited to 1..8, so a 4-bit drain counter always suffices.
  localparam logic [3:0]       DRAIN_LAST = 4'(TREE_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic [3:0]         drain_cnt_q, drain_cnt_d;
  logic               cell_enable_q, cell_enable_d;
  logic [ACT_W-1:0]   act_q, act_d;
  logic [WGT_W-1:0]   wgt_q, wgt_d;
  logic [RES_W-1:0]   result_q, result_d;

  logic               in_ready_c;
  logic               out_valid_c;
  logic               busy_c;
  logic               in_fire;
  logic               out_fire;
  logic               run_done;
  logic               drain_done;

  assign in_fire    = bus_if.in_valid && in_ready_c;
  assign out_fire   = out_valid_c && bus_if.out_ready;
  assign run_done   = (run_cnt_q == RUN_LAST);
  assign drain_done = (drain_cnt_q == DRAIN_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: LOAD is a single settle cycle, RUN and DRAIN leave on
  // their counters, HOLD leaves only on a completed output handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_fire)    state_d = LOAD;
      LOAD:                    state_d = RUN;
      RUN:     if (run_done)   state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = HOLD;
      HOLD:    if (out_fire)   state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Output decode: handshake flags depend only on the current state, so the
  // input handshake never forms a combinational path from in_valid.
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b0;
      end
      HOLD:    out_valid_c = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values.  The enable is computed from the next state so it
  // is a clean register output that is high exactly during RUN.
  always_comb begin
    run_cnt_d     = run_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    act_d         = act_q;
    wgt_d         = wgt_q;
    result_d      = result_q;
    cell_enable_d = (state_d == RUN);

    if (in_fire) begin
      act_d = bus_if.in_act;
      wgt_d = bus_if.in_wgt;
    end

    if (state_q == RUN) begin
      run_cnt_d = run_done ? '0 : run_cnt_q + CNT_W'(1);
    end

    if (state_q == DRAIN) begin
      drain_cnt_d = drain_done ? 4'd0 : drain_cnt_q + 4'd1;
      if (drain_done) begin
        result_d = cell_mult;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q     <= '0;
      drain_cnt_q   <= 4'd0;
      cell_enable_q <= 1'b0;
      act_q         <= '0;
      wgt_q         <= '0;
      result_q      <= '0;
    end else begin
      run_cnt_q     <= run_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      cell_enable_q <= cell_enable_d;
      act_q         <= act_d;
      wgt_q         <= wgt_d;
      result_q      <= result_d;
    end
  end

  assign bus_if.in_ready   = in_ready_c;
  assign bus_if.out_valid  = out_valid_c;
  assign bus_if.out_result = result_q;
  assign busy              = busy_c;
  assign cell_enable       = cell_enable_q;
  assign cell_input_bin    = act_q;
  assign cell_weight_bin   = wgt_q;

`ifdef TLUT_SEQ_PERF_EN
  logic [15:0] ops_q, ops_d;
  logic [15:0] stall_q, stall_d;

  // Saturating counters: completed output handshakes and stalled HOLD cycles.
  always_comb begin
    ops_d   = ops_q;
    stall_d = stall_q;
    if (out_fire && (ops_q != 16'hFFFF)) begin
      ops_d = ops_q + 16'd1;
    end
    if (out_valid_c && !bus_if.out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q   <= 16'd0;
      stall_q <= 16'd0;
    end else begin
      ops_q   <= ops_d;
      stall_q <= stall_d;
    end
  end

  assign perf_ops   = ops_q;
  assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_tlut_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tlut_sequencer
// Self-checking bench for tlut_sequencer.  A negedge monitor keeps a
// transaction-level model (accept cycle + fixed window arithmetic) of the
// default-parameter instance and checks every output every cycle; the main
// process runs a vector table, hand-written corner sequences and a random
// phase.  A second instance with INPUT_WIDTH=2, TREE_LAT=1 checks the
// shortened window.
// ---------------------------------------------------------------------------
module tb_tlut_sequencer;

  localparam int IW  = 4;
  localparam int WW  = 8;
  localparam int DA  = 4;
  localparam int DC  = 4;
  localparam int AW  = 16;
  localparam int DM  = 16;
  localparam int TL  = 3;
  localparam int N   = 1 << IW;
  localparam int AB  = DA * IW;
  localparam int WB  = DC * WW;
  localparam int RB  = DM * AW;
  localparam int IW2 = 2;
  localparam int TL2 = 1;
  localparam int AB2 = DA * IW2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Default-parameter instance.
  tlut_sequencer_if #(.INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW), .DIM_A(DA), .DIM_C(DC),
                      .ACC_WIDTH(AW), .DIM_MULT(DM)) bus ();
  logic          cell_enable;
  logic [AB-1:0] cell_input_bin;
  logic [WB-1:0] cell_weight_bin;
  logic [RB-1:0] cell_mult;
  logic          busy;
`ifdef TLUT_SEQ_PERF_EN
  logic [15:0]   perf_ops, perf_stall;
`endif

  tlut_sequencer #(.INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW), .DIM_A(DA), .DIM_C(DC),
                   .ACC_WIDTH(AW), .DIM_MULT(DM), .TREE_LAT(TL)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus_if          (bus),
    .cell_enable     (cell_enable),
    .cell_input_bin  (cell_input_bin),
    .cell_weight_bin (cell_weight_bin),
    .cell_mult       (cell_mult),
    .busy            (busy)
`ifdef TLUT_SEQ_PERF_EN
    ,
    .perf_ops        (perf_ops),
    .perf_stall      (perf_stall)
`endif
  );

  // Short-window instance.
  tlut_sequencer_if #(.INPUT_WIDTH(IW2), .WEIGHT_WIDTH(WW), .DIM_A(DA), .DIM_C(DC),
                      .ACC_WIDTH(AW), .DIM_MULT(DM)) bus2 ();
  logic           c2_enable;
  logic [AB2-1:0] c2_input_bin;
  logic [WB-1:0]  c2_weight_bin;
  logic [RB-1:0]  c2_mult;
  logic           c2_busy;
`ifdef TLUT_SEQ_PERF_EN
  logic [15:0]    c2_perf_ops, c2_perf_stall;
`endif

  tlut_sequencer #(.INPUT_WIDTH(IW2), .WEIGHT_WIDTH(WW), .DIM_A(DA), .DIM_C(DC),
                   .ACC_WIDTH(AW), .DIM_MULT(DM), .TREE_LAT(TL2)) dut2 (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus_if          (bus2),
    .cell_enable     (c2_enable),
    .cell_input_bin  (c2_input_bin),
    .cell_weight_bin (c2_weight_bin),
    .cell_mult       (c2_mult),
    .busy            (c2_busy)
`ifdef TLUT_SEQ_PERF_EN
    ,
    .perf_ops        (c2_perf_ops),
    .perf_stall      (c2_perf_stall)
`endif
  );

  task automatic checkOutput(input string name, input logic [RB-1:0] actual,
                             input logic [RB-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      if (bad <= 40)
        $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resetPulse();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [RB-1:0] randWide();
    logic [RB-1:0] r;
    r = '0;
    for (int i = 0; i < RB / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Steps until the default instance is idle again, counting enabled cycles.
  task automatic waitIdle(output int ens);
    int guard;
    ens   = 0;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 200) begin
      if (cell_enable === 1'b1) ens++;
      step();
      guard++;
    end
    checkOutput("reach_idle", RB'(bus.in_ready), RB'(1));
  endtask

  // Reference model of the default instance: an accepted set at cycle A is
  // enabled over A+2..A+1+N, its result is the cell value seen in cycle
  // A+1+N+TL, and it is offered from A+2+N+TL until taken.
  bit            mActive = 1'b0;
  int            mAcc    = 0;
  logic [AB-1:0] mAct    = '0;
  logic [WB-1:0] mWgt    = '0;
  logic [RB-1:0] mResult = '0;
  int            mOps    = 0;
  int            mStall  = 0;
  int            enCount = 0;
  int            acceptLog[$];
  bit            expEn;
  bit            expOv;

  always @(negedge clk) begin
    if (!rst_n) begin
      mActive = 1'b0;
      mAct    = '0;
      mWgt    = '0;
      mResult = '0;
      mOps    = 0;
      mStall  = 0;
    end
    expEn = mActive && (cyc >= mAcc + 2) && (cyc <= mAcc + 1 + N);
    expOv = mActive && (cyc >= mAcc + 2 + N + TL);
    checkOutput("mon_cell_enable", RB'(cell_enable), RB'(expEn));
    checkOutput("mon_out_valid", RB'(bus.out_valid), RB'(expOv));
    checkOutput("mon_in_ready", RB'(bus.in_ready), RB'(!mActive));
    checkOutput("mon_busy", RB'(busy), RB'(mActive));
    checkOutput("mon_input_bin", RB'(cell_input_bin), RB'(mAct));
    checkOutput("mon_weight_bin", RB'(cell_weight_bin), RB'(mWgt));
    checkOutput("mon_out_result", bus.out_result, mResult);
`ifdef TLUT_SEQ_PERF_EN
    checkOutput("mon_perf_ops", RB'(perf_ops), RB'(mOps));
    checkOutput("mon_perf_stall", RB'(perf_stall), RB'(mStall));
`endif
    if (rst_n) begin
      if (cell_enable === 1'b1) enCount++;
      if (mActive && cyc == mAcc + 1 + N + TL) mResult = cell_mult;
      if (expOv) begin
        if (bus.out_ready) begin
          mActive = 1'b0;
          if (mOps < 65535) mOps++;
        end else if (mStall < 65535) begin
          mStall++;
        end
      end else if (!mActive && bus.in_valid) begin
        mActive = 1'b1;
        mAcc    = cyc;
        mAct    = bus.in_act;
        mWgt    = bus.in_wgt;
        acceptLog.push_back(cyc);
      end
    end
  end

  typedef struct {
    logic [AB-1:0] act;
    logic [WB-1:0] wgt;
    logic [RB-1:0] mult;
    int            stall;
    int            expLat;
    int            expEn;
    int            expStall;
    logic [RB-1:0] expResult;
  } vec_t;

  vec_t vecs[4];

  // One full transaction from a fresh reset: accept, window, stalled HOLD.
  task automatic applyStimulus(input vec_t v);
    int acc;
    int rise;
    int ens;
    int guard;
    resetPulse();
    cell_mult     = v.mult;
    bus.in_act    = v.act;
    bus.in_wgt    = v.wgt;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    checkOutput("vec_in_ready", RB'(bus.in_ready), RB'(1));
    acc = cyc;
    step();
    bus.in_valid = 1'b0;
    bus.in_act   = AB'($urandom);
    bus.in_wgt   = WB'($urandom);
    ens   = 0;
    guard = 0;
    while (bus.out_valid !== 1'b1 && guard < 100) begin
      if (cell_enable === 1'b1) ens++;
      step();
      guard++;
    end
    rise = cyc;
    checkOutput("vec_latency", RB'(rise - acc), RB'(v.expLat));
    checkOutput("vec_enables", RB'(ens), RB'(v.expEn));
    checkOutput("vec_result", bus.out_result, v.expResult);
    for (int i = 0; i < v.stall; i++) begin
      cell_mult = randWide();
      checkOutput("hold_result", bus.out_result, v.expResult);
      checkOutput("hold_in_ready", RB'(bus.in_ready), RB'(0));
      checkOutput("hold_valid", RB'(bus.out_valid), RB'(1));
      step();
    end
    bus.out_ready = 1'b1;
    checkOutput("ack_result", bus.out_result, v.expResult);
    step();
    bus.out_ready = 1'b0;
    checkOutput("ack_valid_drop", RB'(bus.out_valid), RB'(0));
    checkOutput("ack_in_ready", RB'(bus.in_ready), RB'(1));
`ifdef TLUT_SEQ_PERF_EN
    checkOutput("vec_perf_stall", RB'(perf_stall), RB'(v.expStall));
    checkOutput("vec_perf_ops", RB'(perf_ops), RB'(1));
`endif
  endtask

  int acc;
  int ens;
  int ens2;
  int guard;
  bit sawValid;
  int acc3[$];

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_act    = '0;
    bus.in_wgt    = '0;
    bus.out_ready = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.in_act    = '0;
    bus2.in_wgt    = '0;
    bus2.out_ready = 1'b1;
    cell_mult = '0;
    c2_mult   = {16{16'h0F0F}};

    vecs[0] = '{act: {4'd15, 4'd0, 4'd7, 4'd1}, wgt: {4{8'd3}}, mult: {16{16'h1234}},
                stall: 0, expLat: 21, expEn: 16, expStall: 0, expResult: {16{16'h1234}}};
    vecs[1] = '{act: 16'hFFFF, wgt: 32'hFFFF_FFFF, mult: {16{16'hFFFF}},
                stall: 5, expLat: 21, expEn: 16, expStall: 5, expResult: {16{16'hFFFF}}};
    vecs[2] = '{act: 16'h0000, wgt: 32'h0000_0000, mult: {8{32'hA5A5_5A5A}},
                stall: 1, expLat: 21, expEn: 16, expStall: 1, expResult: {8{32'hA5A5_5A5A}}};
    vecs[3] = '{act: 16'h8421, wgt: 32'h8040_2010, mult: {{8{16'h0000}}, {8{16'hBEEF}}},
                stall: 2, expLat: 21, expEn: 16, expStall: 2, expResult: {{8{16'h0000}}, {8{16'hBEEF}}}};

    repeat (3) step();
    checkOutput("reset_in_ready", RB'(bus.in_ready), RB'(1));
    checkOutput("reset_busy", RB'(busy), RB'(0));
    rst_n = 1'b1;

    // Short window: INPUT_WIDTH=2, TREE_LAT=1.
    bus2.in_act   = 8'h9C;
    bus2.in_wgt   = 32'h0A0B_0C0D;
    bus2.in_valid = 1'b1;
    checkOutput("w2_in_ready", RB'(bus2.in_ready), RB'(1));
    acc = cyc;
    step();
    bus2.in_valid = 1'b0;
    checkOutput("w2_input_bin", RB'(c2_input_bin), RB'(8'h9C));
    checkOutput("w2_weight_bin", RB'(c2_weight_bin), RB'(32'h0A0B_0C0D));
    ens   = 0;
    guard = 0;
    while (bus2.out_valid !== 1'b1 && guard < 50) begin
      if (c2_enable === 1'b1) ens++;
      step();
      guard++;
    end
    checkOutput("w2_latency", RB'(cyc - acc), RB'(2 + (1 << IW2) + TL2));
    checkOutput("w2_enables", RB'(ens), RB'(1 << IW2));
    checkOutput("w2_result", bus2.out_result, {16{16'h0F0F}});
    step();
    checkOutput("w2_back_idle", RB'(bus2.in_ready), RB'(1));

    // Vector table.
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

    // in_valid toggling with new data while busy must be ignored.
    resetPulse();
    cell_mult     = randWide();
    bus.out_ready = 1'b1;
    bus.in_act    = 16'h5A3C;
    bus.in_wgt    = 32'h0102_0304;
    bus.in_valid  = 1'b1;
    step();
    ens = 0;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.in_act   = AB'($urandom);
      bus.in_wgt   = WB'($urandom);
      if (cell_enable === 1'b1) ens++;
      checkOutput("toggle_act_held", RB'(cell_input_bin), RB'(16'h5A3C));
      step();
    end
    bus.in_valid = 1'b0;
    waitIdle(ens2);
    checkOutput("toggle_enables", RB'(ens + ens2), RB'(N));
    bus.in_act   = 16'hC3A5;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    checkOutput("toggle_new_act", RB'(cell_input_bin), RB'(16'hC3A5));
    waitIdle(ens2);

    // Reset in the middle of RUN aborts the window.
    resetPulse();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    acc = cyc;
    step();
    bus.in_valid = 1'b0;
    while (cyc < acc + 10) step();
    checkOutput("abort_pre_enable", RB'(cell_enable), RB'(1));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_enable", RB'(cell_enable), RB'(0));
    checkOutput("abort_busy", RB'(busy), RB'(0));
    checkOutput("abort_in_ready", RB'(bus.in_ready), RB'(1));
    checkOutput("abort_result", bus.out_result, '0);
    checkOutput("abort_input_bin", RB'(cell_input_bin), RB'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.out_valid === 1'b1) sawValid = 1'b1;
      step();
    end
    checkOutput("abort_no_valid", RB'(sawValid), RB'(0));
    bus.in_valid = 1'b1;
    acc = cyc;
    step();
    bus.in_valid = 1'b0;
    guard = 0;
    while (bus.out_valid !== 1'b1 && guard < 100) begin
      step();
      guard++;
    end
    checkOutput("restart_latency", RB'(cyc - acc), RB'(2 + N + TL));
    waitIdle(ens2);

    // Three back-to-back sets with in_valid and out_ready held high.
    resetPulse();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    ens   = 0;
    guard = 0;
    acc3.delete();
    while (acc3.size() < 3 && guard < 200) begin
      if (cell_enable === 1'b1) ens++;
      if (bus.in_ready === 1'b1) acc3.push_back(cyc);
      bus.in_act = AB'($urandom);
      bus.in_wgt = WB'($urandom);
      cell_mult  = randWide();
      step();
      guard++;
    end
    bus.in_valid = 1'b0;
    waitIdle(ens2);
    checkOutput("b2b_accepts", RB'(acc3.size()), RB'(3));
    if (acc3.size() == 3) begin
      checkOutput("b2b_gap1", RB'(acc3[1] - acc3[0]), RB'(3 + N + TL));
      checkOutput("b2b_gap2", RB'(acc3[2] - acc3[1]), RB'(3 + N + TL));
    end
    checkOutput("b2b_enables", RB'(ens + ens2), RB'(3 * N));
`ifdef TLUT_SEQ_PERF_EN
    checkOutput("b2b_perf_ops", RB'(perf_ops), RB'(3));
`endif

    // Random traffic against the monitor model.
    resetPulse();
    enCount = 0;
    acceptLog.delete();
    for (int i = 0; i < 1500; i++) begin
      bus.in_valid  = 1'($urandom % 2);
      bus.in_act    = AB'($urandom);
      bus.in_wgt    = WB'($urandom);
      bus.out_ready = (($urandom % 4) != 0);
      cell_mult     = randWide();
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    waitIdle(ens2);
    checkOutput("rand_enable_total", RB'(enCount), RB'(N * acceptLog.size()));
    checkOutput("rand_accepts_seen", RB'(acceptLog.size() > 20), RB'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
